uart_frame_receiver: RTL and testbench

Serial-to-parallel receive stage that consumes the UART line produced by the transmitter system and returns bytes to the FPGA fabric. It detects start bits on an idle-high line, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and hands each byte to the consumer over a valid/read handshake. It keeps a running CRC-8 over delivered bytes so the consumer can compare it against the transmitter's `crc8`.

---
 rtl/uart_frame_receiver.sv | 133 +++++++++++++
 tb/tb_uart_frame_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_receiver.sv
// UART 8N1 receive stage: start detect, mid-bit sampling, stop check, valid/read handoff
// and a running CRC-8/SMBUS over every delivered byte.
module uart_frame_receiver #(
    parameter int unsigned CLOCKS_PER_BIT = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    input  logic       read,
    input  logic       clear,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_error,
    output logic       overrun,
    output logic [7:0] crc8
);

    localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LastCnt = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfCnt = CW'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e        state;
    logic          sync1;
    logic          line;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Polynomial 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1       <= 1'b1;
            line        <= 1'b1;
            state       <= StIdle;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            crc8        <= '0;
        end else begin
            sync1       <= data_in;
            line        <= sync1;
            frame_error <= 1'b0;

            if (read && valid) begin
                valid <= 1'b0;
            end
            if (clear) begin
                crc8    <= '0;
                overrun <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (!line) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == HalfCnt) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= line ? StIdle : StData;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StData: begin
                    if (cnt == LastCnt) begin
                        cnt            <= '0;
                        shift[bit_idx] <= line;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StStop: begin
                    if (cnt == LastCnt) begin
                        cnt <= '0;
                        if (line) begin
                            state <= StIdle;
                            // A read on this same edge frees the slot for the new byte.
                            if (!valid || read) begin
                                data_out <= shift;
                                valid    <= 1'b1;
                                crc8     <= crc8_step(clear ? 8'h00 : crc8, shift);
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= StWaitHigh;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StWaitHigh: begin
                    // Hold off until the line recovers so a break cannot look like a start bit.
                    if (line) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: table-driven frames, hand corner cases and random frames
// checked against a byte-level reference model.
module tb_uart_frame_receiver;

    localparam int unsigned CPB = 16;
    localparam int unsigned HALF = CPB / 2;
    localparam int STOP_EDGE = HALF + 9 * CPB + 2;

    logic       clock;
    logic       reset;
    logic       data_in;
    logic       read;
    logic       clear;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_error;
    logic       overrun;
    logic [7:0] crc8;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_crc = 8'h00;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       glitch;
        logic       rs;
        logic       cs;
        logic       rstop;
        logic       cstop;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_ovr;
        logic [7:0] e_crc;
    } vec_t;

    vec_t tbl [8];

    uart_frame_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .read       (read),
        .clear      (clear),
        .data_out   (data_out),
        .valid      (valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .crc8       (crc8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // CRC as polynomial remainder: (crc ^ byte) * x^8 mod (x^8 + x^2 + x + 1).
    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = {c ^ b, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return stop;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " data_out"}, data_out, m_data);
        chk({tag, " valid"}, {7'd0, valid}, {7'd0, m_valid});
        chk({tag, " overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
        chk({tag, " crc8"}, crc8, m_crc);
    endtask

    // Hold the line at a level; outputs must not move during the span.
    task automatic idle_span(input int n, input logic level, input string tag);
        logic bad;
        bad = 1'b0;
        data_in = level;
        for (int i = 0; i < n; i++) begin
            tick();
            if (frame_error || valid !== m_valid || data_out !== m_data) bad = 1'b1;
        end
        chk({tag, " quiet"}, {7'd0, bad}, 8'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch,
                              input logic rs, input logic cs, input logic rstop,
                              input logic cstop, input string tag);
        logic vb;
        logic fe_spur;
        fe_spur = 1'b0;
        if (glitch) begin
            idle_span(3, 1'b0, {tag, " glitch low"});
            idle_span(20, 1'b1, {tag, " glitch high"});
        end
        for (int c = 0; c < 10 * int'(CPB); c++) begin
            data_in = frame_bit(b, stop, c / int'(CPB));
            read  = ((c == 0) && rs) || ((c == STOP_EDGE) && rstop);
            clear = ((c == 0) && cs) || ((c == STOP_EDGE) && cstop);
            tick();
            if (c == 0) begin
                if (cs) begin
                    m_crc = 8'h00;
                    m_ovr = 1'b0;
                end
                if (rs) m_valid = 1'b0;
            end
            if (c == STOP_EDGE - 1) chk({tag, " valid before stop"}, {7'd0, valid}, {7'd0, m_valid});
            if (c == STOP_EDGE) begin
                vb = m_valid;
                if (cstop) begin
                    m_crc = 8'h00;
                    m_ovr = 1'b0;
                end
                if (rstop) m_valid = 1'b0;
                if (stop) begin
                    if (!vb || rstop) begin
                        m_data  = b;
                        m_valid = 1'b1;
                        m_crc   = crc_ref(m_crc, b);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                chk({tag, " frame_error at stop"}, {7'd0, frame_error}, {7'd0, ~stop});
                chk({tag, " valid at stop"}, {7'd0, valid}, {7'd0, m_valid});
            end else if (frame_error) begin
                fe_spur = 1'b1;
            end
            read  = 1'b0;
            clear = 1'b0;
        end
        chk({tag, " spurious frame_error"}, {7'd0, fe_spur}, 8'd0);
        if (!stop) begin
            idle_span(40, 1'b0, {tag, " break"});
            idle_span(6, 1'b1, {tag, " recover"});
        end
        chk_model(tag);
    endtask

    initial begin
        //            b      stop  gl    rs    cs    rstop cstop e_data e_v   e_ovr e_crc
        tbl[0] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hF3};
        tbl[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'h07};
        tbl[2] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 8'h1B};
        tbl[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h72};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h72};
        tbl[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'hB4};
        tbl[6] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h72};
        tbl[7] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h72};

        data_in = 1'b1;
        read    = 1'b0;
        clear   = 1'b0;
        reset   = 1'b0;
        tick();
        tick();
        chk("reset data_out", data_out, 8'h00);
        chk("reset valid", {7'd0, valid}, 8'd0);
        chk("reset frame_error", {7'd0, frame_error}, 8'd0);
        chk("reset overrun", {7'd0, overrun}, 8'd0);
        chk("reset crc8", crc8, 8'h00);
        reset = 1'b1;
        idle_span(5, 1'b1, "post reset");

        // Reset in the middle of the data bits of a 0x55 frame.
        for (int c = 0; c < 60; c++) begin
            data_in = frame_bit(8'h55, 1'b1, c / int'(CPB));
            tick();
        end
        reset   = 1'b0;
        data_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        chk_model("mid-frame reset");
        idle_span(200, 1'b1, "after mid-frame reset");

        for (int i = 0; i < 8; i++) begin
            string t;
            t = $sformatf("tbl[%0d]", i);
            send_frame(tbl[i].b, tbl[i].stop, tbl[i].glitch, tbl[i].rs, tbl[i].cs,
                       tbl[i].rstop, tbl[i].cstop, t);
            chk({t, " exp data_out"}, data_out, tbl[i].e_data);
            chk({t, " exp valid"}, {7'd0, valid}, {7'd0, tbl[i].e_valid});
            chk({t, " exp overrun"}, {7'd0, overrun}, {7'd0, tbl[i].e_ovr});
            chk({t, " exp crc8"}, crc8, tbl[i].e_crc);
        end

        // Clear leaves the pending byte alone; a read then releases it.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear crc8", crc8, 8'h00);
        chk("clear overrun", {7'd0, overrun}, 8'd0);
        chk("clear valid kept", {7'd0, valid}, 8'd1);
        chk("clear data_out kept", data_out, 8'hA5);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("read valid", {7'd0, valid}, 8'd0);
        m_crc   = 8'h00;
        m_ovr   = 1'b0;
        m_valid = 1'b0;

        // Read and clear on the exact stop-sample edge of a byte while valid is high.
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre-simul");
        send_frame(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "simul");
        chk("simul data_out", data_out, 8'h02);
        chk("simul valid", {7'd0, valid}, 8'd1);
        chk("simul overrun", {7'd0, overrun}, 8'd0);
        chk("simul crc8", crc8, 8'h0E);

        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0),
                       1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                       ($urandom_range(0, 3) == 0), $sformatf("rand[%0d]", i));
            idle_span($urandom_range(1, 4), 1'b1, "rand gap");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
